// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: conditions the raw device-clocked lines, deframes bytes,
// folds E0/F0 prefixes and emits a toggle-flagged 11-bit key event word.
module ps2_key_rx #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic             clk_s1, clk_s2, dat_s1, dat_s2;
   logic             clk_flt, clk_flt_q;
   logic [FLT_W-1:0] flt_cnt;
   logic             strobe_c;

   logic [1:0]       state, state_nxt;
   logic [2:0]       bitcnt, bitcnt_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             par, par_nxt;
   logic             ext, ext_nxt;
   logic             brk, brk_nxt;
   logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
   logic [10:0]      key_nxt;
   logic             err_nxt;

   // Two-stage synchronizers and ps2_clk glitch filter; idle-high after reset
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1    <= 1'b1;
         clk_s2    <= 1'b1;
         dat_s1    <= 1'b1;
         dat_s2    <= 1'b1;
         clk_flt   <= 1'b1;
         clk_flt_q <= 1'b1;
         flt_cnt   <= '0;
      end else begin
         clk_s1    <= ps2_clk_in;
         clk_s2    <= clk_s1;
         dat_s1    <= ps2_dat_in;
         dat_s2    <= dat_s1;
         clk_flt_q <= clk_flt;
         if (clk_s2 == clk_flt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            clk_flt <= clk_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   // Filtered falling edge of the device clock marks a data sample point
   assign strobe_c = clk_flt_q & ~clk_flt;

   // Frame FSM, timeout watchdog and prefix folding: next-state and output values
   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      shreg_nxt  = shreg;
      par_nxt    = par;
      ext_nxt    = ext;
      brk_nxt    = brk;
      key_nxt    = ps2_key;
      err_nxt    = 1'b0;
      to_cnt_nxt = (state == ST_IDLE) ? '0 : to_cnt + 1'b1;

      if (strobe_c) begin
         to_cnt_nxt = '0;
         case (state)
            ST_IDLE: begin
               if (!dat_s2) begin
                  state_nxt  = ST_DATA;
                  bitcnt_nxt = 3'd0;
               end
            end
            ST_DATA: begin
               shreg_nxt  = {dat_s2, shreg[7:1]};
               bitcnt_nxt = bitcnt + 3'd1;
               if (bitcnt == 3'd7) state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
               par_nxt   = dat_s2;
               state_nxt = ST_STOP;
            end
            default: begin
               state_nxt = ST_IDLE;
               if ((^{shreg, par}) && dat_s2) begin
                  if (shreg == 8'hE0) begin
                     ext_nxt = 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk_nxt = 1'b1;
                  end else if (shreg == 8'h00 || shreg == 8'hFF) begin
                     ext_nxt = 1'b0;
                     brk_nxt = 1'b0;
                  end else begin
                     key_nxt = {~ps2_key[10], ~brk, ext, shreg};
                     ext_nxt = 1'b0;
                     brk_nxt = 1'b0;
                  end
               end else begin
                  err_nxt = 1'b1;
                  ext_nxt = 1'b0;
                  brk_nxt = 1'b0;
               end
            end
         endcase
      end else if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
         // Keyboard stalled mid-frame: abandon it along with any pending prefix
         state_nxt  = ST_IDLE;
         err_nxt    = 1'b1;
         ext_nxt    = 1'b0;
         brk_nxt    = 1'b0;
         to_cnt_nxt = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         bitcnt    <= 3'd0;
         shreg     <= 8'h00;
         par       <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         to_cnt    <= '0;
         ps2_key   <= 11'h000;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bitcnt    <= bitcnt_nxt;
         shreg     <= shreg_nxt;
         par       <= par_nxt;
         ext       <= ext_nxt;
         brk       <= brk_nxt;
         to_cnt    <= to_cnt_nxt;
         ps2_key   <= key_nxt;
         frame_err <= err_nxt;
      end
   end

endmodule
